ctrl_iprog: RTL and testbench

- Instruction sequencer: the producer side of the controller's instruction-word handshake.
- Walks the program counter through a synchronous instruction RAM and registers each word.
- Presents the word as instr_word/iw_valid to the instruction-fetch stage and holds it until consumed by en_fetch.
- Wraps at the configured program length so the upsampler program loops continuously until stopped.

---
 rtl/ctrl_iprog.sv | 102 ++++++++++
 tb/tb_ctrl_iprog.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_iprog.sv
// Instruction sequencer: steps the program counter through a synchronous instruction RAM
// and offers each registered word to the fetch stage over a valid/enable handshake.
module ctrl_iprog #(
  parameter int RFAWIDTH = 5,
  parameter int DAWIDTH  = 12,
  parameter int IAWIDTH  = 8,
  localparam int INSTRWIDTH = 2 + 2*RFAWIDTH + 4*DAWIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic [IAWIDTH-1:0]    prog_len,
  input  logic                  en_fetch,
  output logic                  iw_valid,
  output logic [INSTRWIDTH-1:0] instr_word,
  output logic                  imem_rd,
  output logic [IAWIDTH-1:0]    imem_addr,
  input  logic [INSTRWIDTH-1:0] imem_rdata,
  output logic [IAWIDTH-1:0]    pc,
  output logic                  busy,
  output logic                  wrap
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    VALID = 2'd3
  } state_t;

  state_t             state;
  logic [IAWIDTH-1:0] len;
  logic               stop_pend;
  logic [IAWIDTH-1:0] last_pc;
  logic               at_last;
  logic [IAWIDTH-1:0] next_pc;

  assign last_pc = len - 1'b1;
  assign at_last = (pc == last_pc);
  assign next_pc = at_last ? '0 : pc + 1'b1;
  assign busy    = (state != IDLE);

  // The RAM read is issued on the edge that enters REQ, so imem_rd/imem_addr are registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      len        <= '0;
      pc         <= '0;
      instr_word <= '0;
      iw_valid   <= 1'b0;
      imem_rd    <= 1'b0;
      imem_addr  <= '0;
      wrap       <= 1'b0;
      stop_pend  <= 1'b0;
    end else begin
      wrap    <= 1'b0;
      imem_rd <= 1'b0;
      case (state)
        IDLE: begin
          if (start && (prog_len != '0)) begin
            len       <= prog_len;
            pc        <= '0;
            imem_rd   <= 1'b1;
            imem_addr <= '0;
            stop_pend <= stop;
            state     <= REQ;
          end
        end
        REQ: begin
          if (stop) stop_pend <= 1'b1;
          state <= WAIT;
        end
        WAIT: begin
          if (stop) stop_pend <= 1'b1;
          instr_word <= imem_rdata;
          iw_valid   <= 1'b1;
          state      <= VALID;
        end
        VALID: begin
          if (en_fetch) begin
            iw_valid <= 1'b0;
            pc       <= next_pc;
            wrap     <= at_last;
            if (stop || stop_pend) begin
              stop_pend <= 1'b0;
              state     <= IDLE;
            end else begin
              imem_rd   <= 1'b1;
              imem_addr <= next_pc;
              state     <= REQ;
            end
          end else if (stop) begin
            stop_pend <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_iprog.sv
// Self-checking bench for ctrl_iprog: directed scenarios plus random traffic, all checked
// every cycle against a transaction-level model of the sequencer.
module tb_ctrl_iprog;
  localparam int IAW = 8;
  localparam int IW  = 60;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic           stop = 1'b0;
  logic [IAW-1:0] prog_len = '0;
  logic           en_fetch = 1'b0;
  logic           iw_valid;
  logic [IW-1:0]  instr_word;
  logic           imem_rd;
  logic [IAW-1:0] imem_addr;
  logic [IW-1:0]  imem_rdata = '0;
  logic [IAW-1:0] pc;
  logic           busy;
  logic           wrap;

  int tests_run = 0;
  int tests_failed = 0;
  bit check_en = 1'b0;

  logic [IW-1:0] mem [0:(1<<IAW)-1];

  ctrl_iprog dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .prog_len(prog_len),
    .en_fetch(en_fetch), .iw_valid(iw_valid), .instr_word(instr_word),
    .imem_rd(imem_rd), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .pc(pc), .busy(busy), .wrap(wrap)
  );

  always #5 clk = ~clk;

  // Synchronous instruction RAM: data appears the cycle after the read strobe.
  always @(posedge clk) if (imem_rd) imem_rdata <= mem[imem_addr];

  // Transaction-level model: a running program either waits out the 2-cycle fetch
  // latency or holds a word until it is taken; pc advances modulo the program length.
  bit            m_active, m_valid, m_stop, m_wrap, m_rd;
  int            m_pc, m_len, m_addr, m_delay;
  logic [IW-1:0] m_word;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_active = 0; m_valid = 0; m_stop = 0; m_wrap = 0; m_rd = 0;
      m_pc = 0; m_len = 0; m_addr = 0; m_delay = 0; m_word = '0;
    end else begin
      m_wrap = 0;
      m_rd   = 0;
      if (!m_active) begin
        if (start && prog_len != 0) begin
          m_active = 1; m_len = int'(prog_len); m_pc = 0; m_stop = stop;
          m_rd = 1; m_addr = 0; m_delay = 2;
        end
      end else if (m_valid) begin
        if (en_fetch) begin
          m_valid = 0;
          m_wrap  = (m_pc == m_len - 1);
          m_pc    = (m_pc + 1) % m_len;
          if (stop || m_stop) begin
            m_active = 0; m_stop = 0;
          end else begin
            m_rd = 1; m_addr = m_pc; m_delay = 2;
          end
        end else if (stop) begin
          m_stop = 1;
        end
      end else begin
        if (stop) m_stop = 1;
        m_delay--;
        if (m_delay == 0) begin
          m_valid = 1;
          m_word  = mem[m_pc];
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("iw_valid",   64'(iw_valid),   64'(m_valid));
      checkOutput("instr_word", 64'(instr_word), 64'(m_word));
      checkOutput("imem_rd",    64'(imem_rd),    64'(m_rd));
      checkOutput("imem_addr",  64'(imem_addr),  64'(m_addr));
      checkOutput("pc",         64'(pc),         64'(m_pc));
      checkOutput("busy",       64'(busy),       64'(m_active));
      checkOutput("wrap",       64'(wrap),       64'(m_wrap));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input bit s, input bit st, input bit en, input int pl);
    start    = s;
    stop     = st;
    en_fetch = en;
    prog_len = IAW'(pl);
    step(1);
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < (1 << IAW); i++) mem[i] = IW'(i + 'h100);
    step(2);
    check_en = 1'b1;
    rst_n = 1'b1;
    checkOutput("reset_busy",     64'(busy),       64'd0);
    checkOutput("reset_iw_valid", 64'(iw_valid),   64'd0);
    checkOutput("reset_pc",       64'(pc),         64'd0);

    // 1: three-word loop at full rate
    applyStimulus(1, 0, 1, 3);
    checkOutput("t1_rd_first", 64'(imem_rd), 64'd1);
    step(2);
    checkOutput("t1_valid0", 64'(iw_valid),   64'd1);
    checkOutput("t1_word0",  64'(instr_word), 64'h100);
    step(3);
    checkOutput("t1_word1",  64'(instr_word), 64'h101);
    step(3);
    checkOutput("t1_word2",  64'(instr_word), 64'h102);
    step(1);
    checkOutput("t1_wrap",   64'(wrap), 64'd1);
    checkOutput("t1_pc0",    64'(pc),   64'd0);
    step(2);
    checkOutput("t1_word0b", 64'(instr_word), 64'h100);
    doReset();

    // 2: consumer stalls for 10 cycles, then exactly one transfer
    applyStimulus(1, 0, 0, 5);
    step(12);
    checkOutput("t2_valid_held", 64'(iw_valid),   64'd1);
    checkOutput("t2_word_held",  64'(instr_word), 64'h100);
    checkOutput("t2_pc_held",    64'(pc),         64'd0);
    checkOutput("t2_no_rd",      64'(imem_rd),    64'd0);
    applyStimulus(0, 0, 1, 5);
    en_fetch = 1'b0;
    checkOutput("t2_taken", 64'(iw_valid), 64'd0);
    step(6);
    checkOutput("t2_pc1",   64'(pc),         64'd1);
    checkOutput("t2_word1", 64'(instr_word), 64'h101);
    doReset();

    // 3: stop during the fetch of word 1
    applyStimulus(1, 0, 1, 4);
    step(3);
    applyStimulus(0, 1, 1, 4);
    step(2);
    checkOutput("t3_busy", 64'(busy), 64'd0);
    checkOutput("t3_pc",   64'(pc),   64'd2);
    step(5);
    checkOutput("t3_idle_rd", 64'(imem_rd), 64'd0);

    // 4: zero length ignored, then single-word program
    applyStimulus(1, 0, 1, 0);
    checkOutput("t4_len0_busy", 64'(busy),    64'd0);
    checkOutput("t4_len0_rd",   64'(imem_rd), 64'd0);
    applyStimulus(1, 0, 1, 1);
    step(3);
    checkOutput("t4_wrap_a", 64'(wrap), 64'd1);
    checkOutput("t4_pc_a",   64'(pc),   64'd0);
    step(3);
    checkOutput("t4_wrap_b", 64'(wrap), 64'd1);
    checkOutput("t4_pc_b",   64'(pc),   64'd0);

    // 5: reset while a RAM read is in flight
    doReset();
    applyStimulus(1, 0, 0, 3);
    step(1);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    checkOutput("t5_busy",  64'(busy),       64'd0);
    checkOutput("t5_valid", 64'(iw_valid),   64'd0);
    checkOutput("t5_word",  64'(instr_word), 64'd0);
    step(3);
    checkOutput("t5_no_latch", 64'(instr_word), 64'd0);

    // 6: start in REQ and VALID ignored, length stays 3
    applyStimulus(1, 0, 0, 3);
    applyStimulus(1, 0, 0, 7);
    step(2);
    applyStimulus(1, 0, 0, 9);
    en_fetch = 1'b1;
    step(7);
    checkOutput("t6_wrap", 64'(wrap), 64'd1);
    checkOutput("t6_pc",   64'(pc),   64'd0);

    // start and stop together: one word, then back to idle
    doReset();
    applyStimulus(1, 1, 1, 5);
    step(3);
    checkOutput("ss_busy", 64'(busy), 64'd0);
    checkOutput("ss_pc",   64'(pc),   64'd1);

    // Random traffic with random RAM contents
    for (int i = 0; i < (1 << IAW); i++) mem[i] = {28'($urandom), $urandom};
    for (int c = 0; c < 2000; c++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0,
                    $urandom_range(0, 2) != 0,
                    ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6)));
    end
    rst_n = 1'b1;
    step(2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
